led_pattern_reader: RTL
=======================

LED_PATTERN_READER -- requirements
Module: led_pattern_reader

Interface
REQ-001 Parameter TICK_DIV, default 50000000, WAIT-state length in clk cycles per pattern step; legal range >= 1.
REQ-002 Parameter LAST_ADDR, default 12'hFFF, highest pattern ROM address walked; legal range 1..4095.
REQ-003 clk  input  1  single system clock (200 MHz); all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 run  input  1  level; 1 = step through the pattern, 0 = stop after the current fetch.
REQ-006 dir  input  1  0 = ascending addresses (shift left), 1 = descending addresses (shift right).
REQ-007 rom_en  output  1  read enable to the pattern ROM; registered.
REQ-008 rom_addr  output  12  byte address to the pattern ROM; registered.
REQ-009 rom_data  input  4  ROM read data, valid in the cycle after the edge where rom_en=1 is sampled.
REQ-010 led  output  4  displayed pattern; registered.
REQ-011 frame_done  output  1  one-cycle pulse on address wrap; registered.

Function
REQ-012 FSM states: IDLE, WAIT, FETCH, LATCH.
REQ-013 IDLE: rom_en=0, tick counter held at 0; run=1 -> WAIT next cycle; run=0 -> stay in IDLE.
REQ-014 WAIT: counter increments each cycle from 0; when counter = TICK_DIV-1 -> FETCH and counter clears; exactly TICK_DIV cycles spent in WAIT.
REQ-015 FETCH: exactly 1 cycle; rom_en=1 and rom_addr stable at the current address for the whole cycle; -> LATCH.
REQ-016 LATCH: exactly 1 cycle; rom_en=0; led <= rom_data at the LATCH-ending edge; rom_addr <= next address at the same edge.
REQ-017 After LATCH: -> WAIT if run=1, else -> IDLE; run is sampled only in IDLE and LATCH, so run falling during WAIT or FETCH never aborts the step in progress.
REQ-018 Step period with run held at 1: TICK_DIV+2 cycles between successive led updates.
REQ-019 Next address: dir=0 -> rom_addr+1, LAST_ADDR wraps to 0; dir=1 -> rom_addr-1, 0 wraps to LAST_ADDR; dir sampled only in LATCH.
REQ-020 frame_done=1 for exactly the one cycle following any LATCH edge in which the address wrapped (either direction); otherwise 0.
REQ-021 rom_addr never exceeds LAST_ADDR.
REQ-022 led holds its value in IDLE, WAIT and FETCH; changes only at a LATCH-ending edge.
REQ-023 When run is re-asserted, stepping resumes from the stored rom_addr; the address is not reset.

Reset
REQ-024 rst_n=0 forces immediately (asynchronously): state=IDLE, counter=0, rom_en=0, rom_addr=0, led=4'h0, frame_done=0.
REQ-025 Reset asserted in any state, including FETCH/LATCH, discards the step in progress; no led update occurs.
REQ-026 After rst_n deasserts, the first active edge evaluates IDLE normally.

Verification (TICK_DIV=4, LAST_ADDR=7, ROM model: addr n -> 01,02,04,08 for n mod 4 = 0..3, 1-cycle read latency)
REQ-027 Reset then run=1 at cycle 0 -> WAIT cycles 1-4, FETCH cycle 5 (rom_en=1, rom_addr=0), LATCH cycle 6, led=1 from cycle 7; rom_addr=1; next led=2 from cycle 13.
REQ-028 dir=0, run=1 for 9 steps -> led sequence 1,2,4,8,1,2,4,8,1; frame_done pulses once, in the cycle after the step that read addr 7; rom_addr then 0.
REQ-029 dir=1 from rom_addr=0 -> first step reads addr 0 (led=1), frame_done pulses, rom_addr=7; subsequent led 8,4,2,1.
REQ-030 run dropped during FETCH -> LATCH still completes, led updated, state IDLE next cycle, rom_en stays 0, led holds; run=1 later resumes at the stored address.
REQ-031 rst_n pulsed low mid-LATCH -> rom_en, rom_addr, led, frame_done all 0 before the next edge; the pending led update is lost.
REQ-032 dir toggled during WAIT -> new direction applied at that step's LATCH; TICK_DIV=1 -> step period of 3 cycles.

Source files
------------

// File: rtl/led_pattern_reader.sv
// led_pattern_reader
// Walks a 4-bit pattern ROM one address per step and shows each word on the LEDs.
// Each step waits TICK_DIV cycles, issues a one-cycle read (FETCH), then captures
// the returned word (LATCH) and advances the address in the selected direction.
// The address wraps at 0 / LAST_ADDR. frame_done pulses for one cycle after a wrap.
module led_pattern_reader #(
   parameter int          TICK_DIV  = 50000000,
   parameter logic [11:0] LAST_ADDR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        dir,
   output logic        rom_en,
   output logic [11:0] rom_addr,
   input  logic [3:0]  rom_data,
   output logic [3:0]  led,
   output logic        frame_done
);

   // A single-cycle wait still needs a 1-bit counter, so the width never drops to zero.
   localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FETCH = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              rom_en_reg, rom_en_next;
   logic [11:0]       addr_reg, addr_next;
   logic [3:0]        led_reg, led_next;
   logic              fd_reg, fd_next;
   logic [11:0]       step_addr;
   logic              step_wrap;

   // State register: reset drops straight back to IDLE, abandoning any step in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: run is only looked at in IDLE and LATCH, so a started step always completes.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (run) state_next = ST_WAIT;
         ST_WAIT:  if (cnt_reg == CNT_LAST) state_next = ST_FETCH;
         ST_FETCH: state_next = ST_LATCH;
         ST_LATCH: state_next = run ? ST_WAIT : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Address stepper: the ">=" keeps the ascending wrap safe even if the address were ever past LAST_ADDR.
   always_comb begin
      step_wrap = 1'b0;
      step_addr = addr_reg;
      if (dir) begin
         step_wrap = (addr_reg == 12'd0);
         step_addr = step_wrap ? LAST_ADDR : addr_reg - 1'b1;
      end else begin
         step_wrap = (addr_reg >= LAST_ADDR);
         step_addr = step_wrap ? 12'd0 : addr_reg + 1'b1;
      end
   end

   // Output logic: rom_en is registered from the next state so it is high exactly for the FETCH cycle.
   always_comb begin
      cnt_next    = '0;
      rom_en_next = (state_next == ST_FETCH);
      addr_next   = addr_reg;
      led_next    = led_reg;
      fd_next     = 1'b0;
      if (state_reg == ST_WAIT && cnt_reg != CNT_LAST) begin
         cnt_next = cnt_reg + 1'b1;
      end
      if (state_reg == ST_LATCH) begin
         led_next  = rom_data;
         addr_next = step_addr;
         fd_next   = step_wrap;
      end
   end

   // Datapath registers: counter, ROM port, LED word and wrap pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         rom_en_reg <= 1'b0;
         addr_reg   <= 12'd0;
         led_reg    <= 4'h0;
         fd_reg     <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         rom_en_reg <= rom_en_next;
         addr_reg   <= addr_next;
         led_reg    <= led_next;
         fd_reg     <= fd_next;
      end
   end

   assign rom_en     = rom_en_reg;
   assign rom_addr   = addr_reg;
   assign led        = led_reg;
   assign frame_done = fd_reg;

endmodule
